mc_control_unit: RTL
====================

# mc_control_unit

Multi-cycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath enable and mux select. It replaces the single-cycle opcode decoder in the multi-cycle core, adds `j` and optional `bne`, stalls on a memory-ready handshake, and flags illegal opcodes.

## Interface
- `EN_BNE`, 1: decode opcode 6'b00_0101 as bne; 0 treats it as illegal.
- `EN_JUMP`, 1: decode opcode 6'b00_0010 as j; 0 treats it as illegal.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: opcode, IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite` out 1: unconditional PC load.
- `pcwritecond` out 1: PC load if the branch condition holds.
- `branch_ne` out 1: 1 = condition is ALU-zero==0 (bne); 0 = zero==1 (beq).
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memread`, `memwrite` out 1 each: memory strobes.
- `irwrite` out 1: instruction register load.
- `memtoreg`, `regdst`, `regwrite` out 1 each: register-file write path.
- `alusrca` out 1: 0 = PC, 1 = rs.
- `alusrcb` out 2: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `aluop` out 2: 00 add, 01 sub, 10 funct-decoded.
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `illegal` out 1: one-cycle pulse on an undecodable opcode.
- `state` out 4: current state code, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite equal `mem_ready`. Go to DECODE when mem_ready; otherwise hold.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - lw/sw (10_0011/10_1011) go to MEMADR.
  - R-type (00_0000) goes to EXEC.
  - beq, or bne if EN_BNE, goes to BRANCH.
  - addi (00_1000) goes to ADDIEX.
  - j, if EN_JUMP, goes to JUMP.
  - Any other opcode: `illegal`=1 for this cycle, then go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready, then go to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Go to RWB.
- RWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=01. branch_ne=1 for bne. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
- JUMP: pcwrite=1, pcsrc=10. Go to FETCH.
- Every output not listed for a state is 0.
- `op` is sampled only in DECODE and MEMADR; it is don't-care elsewhere.

## Timing
- Outputs are decoded from the state register only, except FETCH irwrite/pcwrite, which are gated by mem_ready.
- Reset forces state=FETCH immediately and asynchronously. During and after reset, outputs are the FETCH values: memread=1, alusrcb=01, irwrite=pcwrite=mem_ready, all others 0, state=0.
- Cycle counts with zero-wait memory:
  - lw: 5.
  - sw: 4.
  - R-type and addi: 4.
  - beq/bne and j: 3.
  - Illegal opcode: 2.
- Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds exactly one cycle; outputs stay stable while stalled.
- Reset asserted mid-instruction abandons it; no write strobe may be asserted in the cycle reset is high.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum, 4-bit, FETCH=0;
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - ALUOP_ADD/SUB/FUNCT and PCSRC_* encodings.
- One sub-module, `mc_ctrl_decode`: the purely combinational state → control-word decoder. `mc_control_unit` keeps the state register and next-state logic.

## Test plan
- Reset pulse mid-EXEC, mem_ready=1 → state=0 immediately, memread=1, regwrite=0; a lw then runs FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles), with regwrite=1 and memtoreg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite held high for 4 cycles, then FETCH; the instruction takes 7 cycles total.
- R-type then addi → aluop=10 in EXEC, then RWB with regdst=1; aluop=00 with alusrcb=10 in ADDIEX, then ADDIWB with regdst=0.
- beq, then bne with EN_BNE=1 → BRANCH asserts pcwritecond=1 and pcsrc=01, with branch_ne=0 then 1. With EN_BNE=0, bne gives illegal=1 for one cycle and returns to FETCH.
- j → JUMP has pcwrite=1 and pcsrc=10; 3 cycles total.
- op=6'b11_1111 → illegal pulse in DECODE, no write strobes, next state FETCH.
- Stall in FETCH with mem_ready=0 for 2 cycles → irwrite and pcwrite stay 0 until mem_ready rises, then pulse for one cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control unit
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b00_0000;
    localparam logic [5:0] OP_LW    = 6'b10_0011;
    localparam logic [5:0] OP_SW    = 6'b10_1011;
    localparam logic [5:0] OP_BEQ   = 6'b00_0100;
    localparam logic [5:0] OP_BNE   = 6'b00_0101;
    localparam logic [5:0] OP_ADDI  = 6'b00_1000;
    localparam logic [5:0] OP_J     = 6'b00_0010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state to control-word decoder
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       is_bne,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       branch_ne,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc
);

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        branch_ne   = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_RT;
        aluop       = ALUOP_ADD;
        pcsrc       = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                // PC+4 and IR load only commit on the cycle memory delivers
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_IMM_SH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsrc       = PCSRC_ALUOUT;
                branch_ne   = is_bne;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle MIPS main control FSM
module mc_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       branch_ne,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_n;
    logic   bne_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            // BRANCH cannot see op, so remember which flavour was decoded
            if (state_q == S_DECODE)
                bne_q <= EN_BNE && (op == OP_BNE);
        end
    end

    always_comb begin
        state_n = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)                    state_n = S_MEMADR;
                else if (op == OP_RTYPE)                           state_n = S_EXEC;
                else if (op == OP_BEQ || (EN_BNE && op == OP_BNE)) state_n = S_BRANCH;
                else if (op == OP_ADDI)                            state_n = S_ADDIEX;
                else if (EN_JUMP && op == OP_J)                    state_n = S_JUMP;
                else begin
                    illegal = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_MEMADR: state_n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_n = S_FETCH;
            S_EXEC:   state_n = S_RWB;
            S_ADDIEX: state_n = S_ADDIWB;
            default:  state_n = S_FETCH;
        endcase
    end

    assign state = state_q;

    mc_ctrl_decode u_decode (
        .state       (state_q),
        .mem_ready   (mem_ready),
        .is_bne      (bne_q),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .branch_ne   (branch_ne),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .aluop       (aluop),
        .pcsrc       (pcsrc)
    );

endmodule
